// File: rtl/cos_sim_pkg.sv
// Shared types and constants for the cosine-similarity accelerator.
package cos_sim_pkg;

  // Load unit sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    HOLD   = 2'd3
  } load_state_e;

  // Bytes per bus word; low address bits below this must be zero.
  localparam int WORD_BYTES = 4;

  // Full-word byte enable for loads.
  localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage : cos_sim_pkg

// File: rtl/ram_load_unit.sv
// Word-load unit: one load at a time over an OBI-style request/grant/response
// bus, result presented to the write-back mux. Misalignment, bus errors and
// response timeouts are reported via load_err with the data forced to zero.
module ram_load_unit
  import cos_sim_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [RD_W-1:0]   cmd_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] RAM_data,
  output logic              result_src,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              load_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  load_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              stale, stale_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic [RD_W-1:0]   rd_next;
  logic              err_next;
  logic              misaligned;
  logic [ADDR_W-1:0] aligned_addr;

  assign misaligned   = (cmd_addr[OFF_W-1:0] != {OFF_W{1'b0}});
  assign aligned_addr = {cmd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Outputs decoded from registered state only.
  assign cmd_ready  = (state == IDLE) && !stale;
  assign mem_req    = (state == REQ);
  assign wb_valid   = (state == HOLD);
  assign result_src = (state == HOLD);
  assign busy       = (state != IDLE) || stale;
  assign mem_we     = 1'b0;
  assign mem_be     = MEM_BE_FULL;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      stale    <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      RAM_data <= {DATA_W{1'b0}};
      wb_rd    <= {RD_W{1'b0}};
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      stale    <= stale_next;
      mem_addr <= addr_next;
      RAM_data <= data_next;
      wb_rd    <= rd_next;
      load_err <= err_next;
    end
  end

  // Next-state, timeout counter, stale tracking and result capture.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stale_next = stale;
    addr_next  = mem_addr;
    data_next  = RAM_data;
    rd_next    = wb_rd;
    err_next   = load_err;

    // A response owed to a timed-out transaction is swallowed here.
    if (stale && mem_rvalid) begin
      stale_next = 1'b0;
    end else begin
      stale_next = stale;
    end

    case (state)
      IDLE: begin
        if (cmd_valid && !stale) begin
          addr_next = aligned_addr;
          rd_next   = cmd_rd;
          if (misaligned) begin
            data_next  = {DATA_W{1'b0}};
            err_next   = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = WAIT_R;
        end else begin
          state_next = REQ;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          data_next  = mem_err ? {DATA_W{1'b0}} : mem_rdata;
          err_next   = mem_err;
          state_next = HOLD;
        end else if (cnt == CNT_LAST) begin
          // Give up; the response may still arrive later and must be dropped.
          data_next  = {DATA_W{1'b0}};
          err_next   = 1'b1;
          stale_next = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          state_next = WAIT_R;
        end
      end
      HOLD: begin
        if (wb_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : ram_load_unit

// File: tb/tb_ram_load_unit.sv
// Self-checking bench for ram_load_unit with directed and randomized loads.
module tb_ram_load_unit;

  localparam int T      = 4;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_rd;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata, RAM_data;
  logic        result_src, wb_valid, wb_ready, load_err, busy;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          wb_cycle;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    logic        rsrc;
    bit          req_seen;
    logic [31:0] req_addr;
    bit          addr_bad;
    bit          hold_bad;
    bit          ready_early;
    bit          ready_before;
    bit          ready_after;
    bit          busy_low;
    bit          extra_wb;
    bit          bench_to;
  } obs_t;

  typedef struct {
    int          wb_cycle;
    logic [31:0] data;
    logic        err;
    bit          req;
  } exp_t;

  ram_load_unit #(.ADDR_W(32), .DATA_W(32), .RD_W(5), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rd(cmd_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .RAM_data(RAM_data), .result_src(result_src), .wb_rd(wb_rd), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: outcome of one load from the bus timing the bench chooses.
  // Cycle 0 = accept; grant lands gnt_dly cycles after the first request cycle;
  // response rv_dly cycles after grant; more than T cycles is a timeout.
  function automatic exp_t model(input logic [31:0] addr, input int gnt_dly, input int rv_dly,
                                 input logic [31:0] rdata, input logic err);
    exp_t e;
    bit mis, timed;
    mis   = (addr % 4) != 0;
    timed = !mis && (rv_dly > T);
    e.req = !mis;
    e.err = mis || timed || err;
    e.data = e.err ? 32'd0 : rdata;
    if (mis)        e.wb_cycle = 1;
    else if (timed) e.wb_cycle = 1 + gnt_dly + T + 1;
    else            e.wb_cycle = 1 + gnt_dly + rv_dly + 1;
    return e;
  endfunction

  // Drives one command plus the bus/write-back side; records what it observes.
  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rdata, input logic err,
                            input int wb_dly, output obs_t o);
    int c, req_cnt, rv_cycle, hold_cnt;
    bit rv_sent, done;
    o = '{default: 0};
    o.wb_cycle = -1;
    req_cnt = 0; rv_cycle = -1; hold_cnt = 0; rv_sent = 0; done = 0;
    o.ready_before = cmd_ready;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_rd = rd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_rd = 5'($urandom);
    c = 1;
    while (!done && c < BUDGET) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom; wb_ready = 1'b0;
      if (cmd_ready) o.ready_early = 1;
      if (mem_req) begin
        if (!o.req_seen) begin o.req_seen = 1; o.req_addr = mem_addr; end
        else if (mem_addr !== o.req_addr) o.addr_bad = 1;
        req_cnt++;
        if (req_cnt == gnt_dly + 1) begin mem_gnt = 1'b1; rv_cycle = c + rv_dly; end
      end
      if (c == rv_cycle) begin
        mem_rvalid = 1'b1; mem_err = err; mem_rdata = rdata; rv_sent = 1;
      end
      if (wb_valid) begin
        if (o.wb_cycle < 0) begin
          o.wb_cycle = c; o.data = RAM_data; o.rd = wb_rd; o.err = load_err; o.rsrc = result_src;
        end else if (RAM_data !== o.data || wb_rd !== o.rd || load_err !== o.err || result_src !== 1'b1) begin
          o.hold_bad = 1;
        end
        hold_cnt++;
        if (hold_cnt == wb_dly + 1) begin wb_ready = 1'b1; done = 1; end
      end
      @(posedge clk); #1; c++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; wb_ready = 1'b0;
    if (!done) o.bench_to = 1;
    // A late response still owed after a timeout.
    while (rv_cycle >= 0 && !rv_sent && c < BUDGET) begin
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (cmd_ready) o.ready_early = 1;
      if (!busy) o.busy_low = 1;
      if (wb_valid) o.extra_wb = 1;
      if (c == rv_cycle) begin
        mem_rvalid = 1'b1; mem_err = err; mem_rdata = rdata; rv_sent = 1;
      end
      @(posedge clk); #1; c++;
    end
    mem_rvalid = 1'b0; mem_err = 1'b0;
    if (rv_cycle >= 0 && !rv_sent) o.bench_to = 1;
    o.ready_after = cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rd = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; wb_ready = 1'b0;
    #2;
    n_checks++;
    if ({cmd_ready, mem_req, wb_valid, result_src, load_err, busy, mem_we} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1000000",
        {cmd_ready, mem_req, wb_valid, result_src, load_err, busy, mem_we});
    end
    n_checks++;
    if (mem_addr !== 32'd0 || RAM_data !== 32'd0 || wb_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h data %h rd %0d expected all zero", mem_addr, RAM_data, wb_rd);
    end
    n_checks++;
    if (mem_be !== 4'hF) begin n_fail++; $display("FAIL reset_be: got %h expected f", mem_be); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready %b busy %b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_aligned();
    obs_t o;
    drive_load(32'h0000_0100, 5'd7, 0, 1, 32'hDEAD_BEEF, 1'b0, 0, o);
    n_checks++;
    if (o.wb_cycle !== 3) begin n_fail++; $display("FAIL aligned_latency: got %0d expected 3", o.wb_cycle); end
    n_checks++;
    if (o.data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL aligned_data: got %h expected deadbeef", o.data); end
    n_checks++;
    if (o.rd !== 5'd7 || o.rsrc !== 1'b1 || o.err !== 1'b0) begin
      n_fail++; $display("FAIL aligned_ctrl: rd %0d src %b err %b expected 7 1 0", o.rd, o.rsrc, o.err);
    end
    n_checks++;
    if (o.req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL aligned_addr: got %h expected 100", o.req_addr); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    drive_load(32'h0000_02A4, 5'd19, 3, 2, 32'h0BAD_F00D, 1'b0, 4, o);
    n_checks++;
    if (o.addr_bad || o.req_addr !== 32'h0000_02A4) begin
      n_fail++; $display("FAIL bp_addr_stable: got %h unstable %0d expected 2a4 0", o.req_addr, o.addr_bad);
    end
    n_checks++;
    if (o.hold_bad) begin n_fail++; $display("FAIL bp_hold_stable: got unstable expected stable"); end
    n_checks++;
    if (o.ready_early || !o.ready_after) begin
      n_fail++; $display("FAIL bp_cmd_ready: early %0d after %0d expected 0 1", o.ready_early, o.ready_after);
    end
    n_checks++;
    if (o.wb_cycle !== 7 || o.data !== 32'h0BAD_F00D || o.rd !== 5'd19) begin
      n_fail++; $display("FAIL bp_result: cycle %0d data %h rd %0d expected 7 0badf00d 19", o.wb_cycle, o.data, o.rd);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    drive_load(32'h0000_0102, 5'd3, 0, 1, 32'hFFFF_FFFF, 1'b0, 1, o);
    n_checks++;
    if (o.req_seen) begin n_fail++; $display("FAIL mis_no_req: got mem_req expected none"); end
    n_checks++;
    if (o.wb_cycle !== 1 || o.err !== 1'b1 || o.data !== 32'd0) begin
      n_fail++; $display("FAIL mis_result: cycle %0d err %b data %h expected 1 1 0", o.wb_cycle, o.err, o.data);
    end
  endtask

  task automatic test_bus_error();
    obs_t o;
    drive_load(32'h0000_0040, 5'd9, 1, 2, 32'h0000_1234, 1'b1, 0, o);
    n_checks++;
    if (o.data !== 32'd0 || o.err !== 1'b1 || o.rd !== 5'd9) begin
      n_fail++; $display("FAIL bus_err: data %h err %b rd %0d expected 0 1 9", o.data, o.err, o.rd);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    // Response exactly on the last waiting cycle is still accepted.
    drive_load(32'h0000_0080, 5'd4, 0, T, 32'h5555_AAAA, 1'b0, 0, o);
    n_checks++;
    if (o.err !== 1'b0 || o.data !== 32'h5555_AAAA || o.wb_cycle !== T + 2) begin
      n_fail++; $display("FAIL to_edge_ok: err %b data %h cycle %0d expected 0 5555aaaa %0d", o.err, o.data, o.wb_cycle, T + 2);
    end
    // No response in time: error result, then the late response is swallowed.
    drive_load(32'h0000_0084, 5'd5, 0, 10, 32'h7777_7777, 1'b0, 0, o);
    n_checks++;
    if (o.err !== 1'b1 || o.data !== 32'd0 || o.wb_cycle !== T + 2) begin
      n_fail++; $display("FAIL to_result: err %b data %h cycle %0d expected 1 0 %0d", o.err, o.data, o.wb_cycle, T + 2);
    end
    n_checks++;
    if (o.ready_early || o.busy_low) begin
      n_fail++; $display("FAIL to_stale_block: ready %0d busy_low %0d expected 0 0", o.ready_early, o.busy_low);
    end
    n_checks++;
    if (!o.ready_after || o.bench_to) begin
      n_fail++; $display("FAIL to_stale_clear: ready %0d bench_to %0d expected 1 0", o.ready_after, o.bench_to);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wb_valid !== 1'b0 || o.extra_wb) begin
        n_fail++; $display("FAIL to_late_data: wb_valid %b expected 0", wb_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    drive_load(32'h0000_1000, 5'd1, 0, 1, 32'h1111_2222, 1'b0, 0, o1);
    drive_load(32'h0000_1004, 5'd2, 0, 1, 32'h3333_4444, 1'b0, 0, o2);
    n_checks++;
    if (!o2.ready_before || o2.wb_cycle !== 3) begin
      n_fail++; $display("FAIL b2b_accept: ready %0d cycle %0d expected 1 3", o2.ready_before, o2.wb_cycle);
    end
    n_checks++;
    if (o1.data !== 32'h1111_2222 || o2.data !== 32'h3333_4444 || o2.rd !== 5'd2) begin
      n_fail++; $display("FAIL b2b_data: %h %h rd %0d expected 11112222 33334444 2", o1.data, o2.data, o2.rd);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    drive_load(32'h0000_0300, 5'd11, 0, 1, 32'hCAFE_0001, 1'b0, 0, o);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0200; cmd_rd = 5'd12;
    @(posedge clk); #1;
    cmd_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, mem_req, wb_valid, result_src, load_err, busy} !== 6'b100000 ||
        mem_addr !== 32'd0 || RAM_data !== 32'd0 || wb_rd !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid: flags %b addr %h data %h rd %0d expected 100000 0 0 0",
        {cmd_ready, mem_req, wb_valid, result_src, load_err, busy}, mem_addr, RAM_data, wb_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_load(32'h0000_0208, 5'd13, 1, 1, 32'hA5A5_5A5A, 1'b0, 0, o);
    n_checks++;
    if (o.data !== 32'hA5A5_5A5A || o.rd !== 5'd13 || o.err !== 1'b0 || o.wb_cycle !== 4) begin
      n_fail++; $display("FAIL rst_fresh: data %h rd %0d err %b cycle %0d expected a5a55a5a 13 0 4",
        o.data, o.rd, o.err, o.wb_cycle);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [31:0] addr, rdata;
    logic [4:0]  rd;
    logic        err;
    int gd, rv, wd;
    for (int n = 0; n < 25; n++) begin
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      rd = 5'($urandom); rdata = $urandom; err = ($urandom_range(0, 3) == 0);
      gd = $urandom_range(0, 3); rv = $urandom_range(1, T + 3); wd = $urandom_range(0, 3);
      e = model(addr, gd, rv, rdata, err);
      drive_load(addr, rd, gd, rv, rdata, err, wd, o);
      n_checks++;
      if (o.wb_cycle !== e.wb_cycle) begin
        n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, o.wb_cycle, e.wb_cycle);
      end
      n_checks++;
      if (o.data !== e.data || o.err !== e.err) begin
        n_fail++; $display("FAIL rnd%0d_result: data %h err %b expected %h %b", n, o.data, o.err, e.data, e.err);
      end
      n_checks++;
      if (o.rd !== rd || o.rsrc !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_rd: rd %0d src %b expected %0d 1", n, o.rd, o.rsrc, rd);
      end
      n_checks++;
      if (o.req_seen !== e.req || (e.req && o.req_addr !== (addr & 32'hFFFF_FFFC))) begin
        n_fail++; $display("FAIL rnd%0d_bus: req %0d addr %h expected %0d %h", n, o.req_seen, o.req_addr, e.req, addr & 32'hFFFF_FFFC);
      end
      n_checks++;
      if (o.addr_bad || o.hold_bad || o.ready_early || !o.ready_after || o.bench_to || o.extra_wb) begin
        n_fail++; $display("FAIL rnd%0d_proto: addr %0d hold %0d early %0d after %0d to %0d extra %0d expected 0 0 0 1 0 0",
          n, o.addr_bad, o.hold_bad, o.ready_early, o.ready_after, o.bench_to, o.extra_wb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_backpressure();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_load_unit
